// File: rtl/commit_stage_pkg.sv
// Shared types and constants for the in-order commit (retire) stage.
package commit_stage_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned ROB_TAG_LEN = 5;
   localparam int unsigned REG_IDX_W   = 5;
   localparam int unsigned ST_SIZE_W   = 3;

   localparam logic [REG_IDX_W-1:0] ZERO_REG = REG_IDX_W'(0);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      ST_WAIT = 2'd1,
      HALTED  = 2'd2
   } COMMIT_STATE;

   // ROB head entry as seen by the commit stage
   typedef struct packed {
      logic                   valid;
      logic                   done;
      logic [ROB_TAG_LEN-1:0] tag;
      logic [REG_IDX_W-1:0]   dest_idx;
      logic [XLEN-1:0]        value;
      logic                   wr_mem;
      logic [XLEN-1:0]        st_data;
      logic [ST_SIZE_W-1:0]   mem_size;
      logic                   mispredict;
      logic [XLEN-1:0]        target_pc;
      logic                   halt;
      logic                   illegal;
   } ROB_HEAD_PACKET;

endpackage

// File: rtl/commit_stage.sv
// In-order retirement of the ROB head: register writeback, maptable release,
// store drain over req/ack, branch-mispredict flush and halt/illegal freeze.
module commit_stage
   import commit_stage_pkg::*;
#(
   parameter int unsigned CNT_W = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   head_valid,
   input  logic                   head_done,
   input  logic [ROB_TAG_LEN-1:0] head_tag,
   input  logic [REG_IDX_W-1:0]   head_dest_idx,
   input  logic [XLEN-1:0]        head_value,
   input  logic                   head_wr_mem,
   input  logic [XLEN-1:0]        head_st_data,
   input  logic [ST_SIZE_W-1:0]   head_mem_size,
   input  logic                   head_mispredict,
   input  logic [XLEN-1:0]        head_target_pc,
   input  logic                   head_halt,
   input  logic                   head_illegal,
   input  logic                   st_ack,
   output logic                   rob_retire,
   output logic                   wb_reg_wr_en_out,
   output logic [REG_IDX_W-1:0]   wb_reg_wr_idx_out,
   output logic [XLEN-1:0]        wb_reg_wr_data_out,
   output logic                   mt_clear_en,
   output logic [REG_IDX_W-1:0]   mt_clear_idx,
   output logic [ROB_TAG_LEN-1:0] mt_clear_tag,
   output logic                   st_req,
   output logic [XLEN-1:0]        st_addr,
   output logic [XLEN-1:0]        st_data,
   output logic [ST_SIZE_W-1:0]   st_size,
   output logic                   kill,
   output logic [XLEN-1:0]        redirect_pc,
   output logic                   halted,
   output logic                   halt_illegal,
   output logic [CNT_W-1:0]       retired_cnt
);

   ROB_HEAD_PACKET w_head;
   COMMIT_STATE    r_state;
   COMMIT_STATE    w_next_state;
   logic           w_retire;
   logic           w_st_start;
   logic           w_freeze;
   logic           w_effects;
   logic           w_dest_wr;

   logic                   r_wb_en;
   logic [REG_IDX_W-1:0]   r_wb_idx;
   logic [XLEN-1:0]        r_wb_data;
   logic                   r_mt_en;
   logic [REG_IDX_W-1:0]   r_mt_idx;
   logic [ROB_TAG_LEN-1:0] r_mt_tag;
   logic                   r_st_req;
   logic [XLEN-1:0]        r_st_addr;
   logic [XLEN-1:0]        r_st_data;
   logic [ST_SIZE_W-1:0]   r_st_size;
   logic                   r_kill;
   logic [XLEN-1:0]        r_redirect_pc;
   logic                   r_halt_illegal;
   logic [CNT_W-1:0]       r_retired_cnt;

   assign w_head = '{
      valid:      head_valid,
      done:       head_done,
      tag:        head_tag,
      dest_idx:   head_dest_idx,
      value:      head_value,
      wr_mem:     head_wr_mem,
      st_data:    head_st_data,
      mem_size:   head_mem_size,
      mispredict: head_mispredict,
      target_pc:  head_target_pc,
      halt:       head_halt,
      illegal:    head_illegal
   };

   // Halt/illegal heads retire without any architectural side effect
   assign w_freeze  = w_head.halt | w_head.illegal;
   assign w_effects = w_retire & ~w_freeze;
   assign w_dest_wr = w_effects & (w_head.dest_idx != ZERO_REG);

   // FSM state register
   always_ff @(posedge clock) begin
      if (!reset) r_state <= RUN;
      else        r_state <= w_next_state;
   end

   // FSM next-state and retire/store-start decisions
   always_comb begin
      w_next_state = r_state;
      w_retire     = 1'b0;
      w_st_start   = 1'b0;
      case (r_state)
         RUN: begin
            if (w_head.valid && w_head.done) begin
               if (w_freeze) begin
                  w_retire     = 1'b1;
                  w_next_state = HALTED;
               end else if (w_head.wr_mem) begin
                  w_st_start   = 1'b1;
                  w_next_state = ST_WAIT;
               end else begin
                  w_retire     = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (st_ack) begin
               w_retire     = 1'b1;
               w_next_state = RUN;
            end
         end
         HALTED: begin
            w_next_state = HALTED;
         end
         default: begin
            w_next_state = RUN;
         end
      endcase
   end

   // Register writeback and maptable release, one edge after retire
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wb_en   <= 1'b0;
         r_wb_idx  <= '0;
         r_wb_data <= '0;
         r_mt_en   <= 1'b0;
         r_mt_idx  <= '0;
         r_mt_tag  <= '0;
      end else begin
         r_wb_en <= w_dest_wr;
         r_mt_en <= w_dest_wr;
         if (w_dest_wr) begin
            r_wb_idx  <= w_head.dest_idx;
            r_wb_data <= w_head.value;
            r_mt_idx  <= w_head.dest_idx;
            r_mt_tag  <= w_head.tag;
         end
      end
   end

   // Store request: raised on entry to ST_WAIT, payload frozen until ack
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_st_req  <= 1'b0;
         r_st_addr <= '0;
         r_st_data <= '0;
         r_st_size <= '0;
      end else if (w_st_start) begin
         r_st_req  <= 1'b1;
         r_st_addr <= w_head.value;
         r_st_data <= w_head.st_data;
         r_st_size <= w_head.mem_size;
      end else if (r_state == ST_WAIT && st_ack) begin
         r_st_req  <= 1'b0;
      end
   end

   // Mispredict flush pulse, halt cause and retired-instruction counter
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_kill         <= 1'b0;
         r_redirect_pc  <= '0;
         r_halt_illegal <= 1'b0;
         r_retired_cnt  <= '0;
      end else begin
         r_kill <= w_effects & w_head.mispredict;
         if (w_effects && w_head.mispredict) r_redirect_pc <= w_head.target_pc;
         if (w_retire && w_freeze) r_halt_illegal <= w_head.illegal;
         if (w_retire) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
      end
   end

   assign rob_retire         = w_retire;
   assign wb_reg_wr_en_out   = r_wb_en;
   assign wb_reg_wr_idx_out  = r_wb_idx;
   assign wb_reg_wr_data_out = r_wb_data;
   assign mt_clear_en        = r_mt_en;
   assign mt_clear_idx       = r_mt_idx;
   assign mt_clear_tag       = r_mt_tag;
   assign st_req             = r_st_req;
   assign st_addr            = r_st_addr;
   assign st_data            = r_st_data;
   assign st_size            = r_st_size;
   assign kill               = r_kill;
   assign redirect_pc        = r_redirect_pc;
   assign halted             = (r_state == HALTED);
   assign halt_illegal       = r_halt_illegal;
   assign retired_cnt        = r_retired_cnt;

endmodule

// File: tb/tb_commit_stage.sv
// Directed self-checking bench for commit_stage.
module tb_commit_stage;
   import commit_stage_pkg::*;

   localparam int unsigned CNT_W = 64;

   logic                   clk;
   logic                   reset;
   logic                   head_valid;
   logic                   head_done;
   logic [ROB_TAG_LEN-1:0] head_tag;
   logic [REG_IDX_W-1:0]   head_dest_idx;
   logic [XLEN-1:0]        head_value;
   logic                   head_wr_mem;
   logic [XLEN-1:0]        head_st_data;
   logic [ST_SIZE_W-1:0]   head_mem_size;
   logic                   head_mispredict;
   logic [XLEN-1:0]        head_target_pc;
   logic                   head_halt;
   logic                   head_illegal;
   logic                   st_ack;
   logic                   rob_retire;
   logic                   wb_reg_wr_en_out;
   logic [REG_IDX_W-1:0]   wb_reg_wr_idx_out;
   logic [XLEN-1:0]        wb_reg_wr_data_out;
   logic                   mt_clear_en;
   logic [REG_IDX_W-1:0]   mt_clear_idx;
   logic [ROB_TAG_LEN-1:0] mt_clear_tag;
   logic                   st_req;
   logic [XLEN-1:0]        st_addr;
   logic [XLEN-1:0]        st_data;
   logic [ST_SIZE_W-1:0]   st_size;
   logic                   kill;
   logic [XLEN-1:0]        redirect_pc;
   logic                   halted;
   logic                   halt_illegal;
   logic [CNT_W-1:0]       retired_cnt;

   int n_pass  = 0;
   int n_total = 0;

   commit_stage #(.CNT_W(CNT_W)) dut (
      .clock              (clk),
      .reset              (reset),
      .head_valid         (head_valid),
      .head_done          (head_done),
      .head_tag           (head_tag),
      .head_dest_idx      (head_dest_idx),
      .head_value         (head_value),
      .head_wr_mem        (head_wr_mem),
      .head_st_data       (head_st_data),
      .head_mem_size      (head_mem_size),
      .head_mispredict    (head_mispredict),
      .head_target_pc     (head_target_pc),
      .head_halt          (head_halt),
      .head_illegal       (head_illegal),
      .st_ack             (st_ack),
      .rob_retire         (rob_retire),
      .wb_reg_wr_en_out   (wb_reg_wr_en_out),
      .wb_reg_wr_idx_out  (wb_reg_wr_idx_out),
      .wb_reg_wr_data_out (wb_reg_wr_data_out),
      .mt_clear_en        (mt_clear_en),
      .mt_clear_idx       (mt_clear_idx),
      .mt_clear_tag       (mt_clear_tag),
      .st_req             (st_req),
      .st_addr            (st_addr),
      .st_data            (st_data),
      .st_size            (st_size),
      .kill               (kill),
      .redirect_pc        (redirect_pc),
      .halted             (halted),
      .halt_illegal       (halt_illegal),
      .retired_cnt        (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Advance one edge and settle past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_head();
      head_valid      = 1'b0;
      head_done       = 1'b0;
      head_tag        = '0;
      head_dest_idx   = '0;
      head_value      = '0;
      head_wr_mem     = 1'b0;
      head_st_data    = '0;
      head_mem_size   = '0;
      head_mispredict = 1'b0;
      head_target_pc  = '0;
      head_halt       = 1'b0;
      head_illegal    = 1'b0;
   endtask

   initial begin
      reset  = 1'b0;
      st_ack = 1'b0;
      idle_head();
      tick();
      tick();
      chk("rst_cnt",    retired_cnt, 64'd0);
      chk("rst_st_req", st_req, 64'd0);
      chk("rst_halted", halted, 64'd0);
      chk("rst_kill",   kill, 64'd0);
      chk("rst_wb_en",  wb_reg_wr_en_out, 64'd0);
      reset = 1'b1;

      // ADD x5 <- 0x1234
      head_valid = 1'b1; head_done = 1'b1; head_tag = 5'd3;
      head_dest_idx = 5'd5; head_value = 32'h1234;
      #1 chk("add_retire", rob_retire, 64'd1);
      tick();
      chk("add_wb_en",   wb_reg_wr_en_out, 64'd1);
      chk("add_wb_idx",  wb_reg_wr_idx_out, 64'd5);
      chk("add_wb_data", wb_reg_wr_data_out, 64'h1234);
      chk("add_mt_en",   mt_clear_en, 64'd1);
      chk("add_mt_idx",  mt_clear_idx, 64'd5);
      chk("add_mt_tag",  mt_clear_tag, 64'd3);
      chk("add_cnt",     retired_cnt, 64'd1);

      // Head not yet done: hold
      head_done = 1'b0;
      #1 chk("notdone_retire", rob_retire, 64'd0);
      tick();
      chk("notdone_wb_en", wb_reg_wr_en_out, 64'd0);
      chk("notdone_cnt",   retired_cnt, 64'd1);

      // x0 destination
      head_done = 1'b1; head_dest_idx = 5'd0; head_value = 32'h55;
      #1 chk("x0_retire", rob_retire, 64'd1);
      tick();
      chk("x0_wb_en", wb_reg_wr_en_out, 64'd0);
      chk("x0_mt_en", mt_clear_en, 64'd0);
      chk("x0_cnt",   retired_cnt, 64'd2);

      // Store, ack arrives three cycles after the request edge
      head_wr_mem = 1'b1; head_value = 32'h100; head_st_data = 32'hAB; head_mem_size = 3'd2;
      #1 chk("st_run_retire", rob_retire, 64'd0);
      tick();
      chk("st_req_up", st_req, 64'd1);
      for (int i = 0; i < 2; i++) begin
         chk("st_wait_retire", rob_retire, 64'd0);
         tick();
         chk("st_req_hold", st_req, 64'd1);
         chk("st_addr",     st_addr, 64'h100);
         chk("st_data",     st_data, 64'hAB);
         chk("st_size",     st_size, 64'd2);
      end
      chk("st_cnt_wait", retired_cnt, 64'd2);
      st_ack = 1'b1;
      #1 chk("st_ack_retire", rob_retire, 64'd1);
      head_wr_mem = 1'b0; head_valid = 1'b0;
      tick();
      st_ack = 1'b0;
      chk("st_req_drop", st_req, 64'd0);
      chk("st_cnt",      retired_cnt, 64'd3);

      // Stray ack in RUN is ignored
      st_ack = 1'b1;
      #1 chk("stray_ack_retire", rob_retire, 64'd0);
      tick();
      st_ack = 1'b0;
      chk("stray_ack_st_req", st_req, 64'd0);
      chk("stray_ack_cnt",    retired_cnt, 64'd3);

      // Mispredicted JAL x1 -> 0x400
      head_valid = 1'b1; head_done = 1'b1; head_tag = 5'd7; head_dest_idx = 5'd1;
      head_value = 32'h404; head_mispredict = 1'b1; head_target_pc = 32'h400;
      #1 chk("jal_retire", rob_retire, 64'd1);
      tick();
      idle_head();
      chk("jal_kill",     kill, 64'd1);
      chk("jal_redirect", redirect_pc, 64'h400);
      chk("jal_wb_en",    wb_reg_wr_en_out, 64'd1);
      chk("jal_wb_idx",   wb_reg_wr_idx_out, 64'd1);
      chk("jal_wb_data",  wb_reg_wr_data_out, 64'h404);
      chk("jal_mt_tag",   mt_clear_tag, 64'd7);
      chk("jal_cnt",      retired_cnt, 64'd4);
      tick();
      chk("jal_kill_drop", kill, 64'd0);
      chk("jal_wb_drop",   wb_reg_wr_en_out, 64'd0);

      // Store with ack in the first ST_WAIT cycle
      head_valid = 1'b1; head_done = 1'b1; head_wr_mem = 1'b1;
      head_value = 32'h200; head_st_data = 32'h55; head_mem_size = 3'd0;
      tick();
      chk("fast_st_req", st_req, 64'd1);
      chk("fast_st_addr", st_addr, 64'h200);
      st_ack = 1'b1;
      #1 chk("fast_st_retire", rob_retire, 64'd1);
      idle_head();
      tick();
      st_ack = 1'b0;
      chk("fast_st_drop", st_req, 64'd0);
      chk("fast_st_cnt",  retired_cnt, 64'd5);

      // Reset while a store is waiting for ack
      head_valid = 1'b1; head_done = 1'b1; head_wr_mem = 1'b1; head_value = 32'h300;
      tick();
      chk("rstw_st_req_up", st_req, 64'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rstw_st_req", st_req, 64'd0);
      chk("rstw_cnt",    retired_cnt, 64'd0);
      head_wr_mem = 1'b0; head_dest_idx = 5'd2; head_value = 32'h9;
      #1 chk("rstw_run_retire", rob_retire, 64'd1);
      tick();
      chk("rstw_cnt_after", retired_cnt, 64'd1);

      // WFI freezes the stage without a register write
      head_halt = 1'b1; head_dest_idx = 5'd3;
      #1 chk("wfi_retire", rob_retire, 64'd1);
      tick();
      head_halt = 1'b0;
      chk("wfi_halted",  halted, 64'd1);
      chk("wfi_illegal", halt_illegal, 64'd0);
      chk("wfi_wb_en",   wb_reg_wr_en_out, 64'd0);
      chk("wfi_cnt",     retired_cnt, 64'd2);
      #1 chk("halted_retire", rob_retire, 64'd0);
      tick();
      chk("halted_cnt",   retired_cnt, 64'd2);
      chk("halted_wb_en", wb_reg_wr_en_out, 64'd0);
      chk("halted_stay",  halted, 64'd1);

      // Reset releases the freeze; illegal instruction then freezes again
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rsth_halted", halted, 64'd0);
      head_illegal = 1'b1;
      #1 chk("ill_retire", rob_retire, 64'd1);
      tick();
      idle_head();
      chk("ill_halted",  halted, 64'd1);
      chk("ill_illegal", halt_illegal, 64'd1);
      chk("ill_wb_en",   wb_reg_wr_en_out, 64'd0);
      chk("ill_cnt",     retired_cnt, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
